// File: rtl/tone_synth.sv
// tone_synth: multi-channel square-wave tone generator with a shared buzzer mixer.
// Each channel turns a semitone index into a half-period taken from a constant
// equal-temperament ROM and toggles its tone output every half-period. Retunes
// take effect only on waveform edges, so the output never shows a short pulse.
// An optional hold timer silences a channel that has not been re-strobed for
// HOLD_CLKS clocks.
module tone_synth #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned HOLD_CLKS = 0,
  parameter int unsigned MIX_MODE  = 0,
  parameter int unsigned SLOT_CLKS = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*CHANNELS-1:0] note_in,
  input  logic [CHANNELS-1:0]   note_vld,
  output logic [CHANNELS-1:0]   tone,
  output logic [CHANNELS-1:0]   active,
  output logic                  beep
);

  localparam int unsigned SLOT_W = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Integer note frequencies in Hz, index 1 = C#3 up to 59 = B7.
  function automatic int unsigned note_hz(input int unsigned idx);
    case (idx)
      1:  return 138;  2:  return 146;  3:  return 155;  4:  return 164;
      5:  return 174;  6:  return 184;  7:  return 195;  8:  return 207;
      9:  return 220;  10: return 233;  11: return 246;  12: return 261;
      13: return 277;  14: return 293;  15: return 311;  16: return 329;
      17: return 349;  18: return 369;  19: return 391;  20: return 415;
      21: return 440;  22: return 466;  23: return 493;  24: return 523;
      25: return 554;  26: return 587;  27: return 622;  28: return 659;
      29: return 698;  30: return 739;  31: return 783;  32: return 830;
      33: return 880;  34: return 932;  35: return 987;  36: return 1046;
      37: return 1108; 38: return 1174; 39: return 1244; 40: return 1318;
      41: return 1396; 42: return 1479; 43: return 1567; 44: return 1661;
      45: return 1760; 46: return 1864; 47: return 1975; 48: return 2093;
      49: return 2217; 50: return 2349; 51: return 2489; 52: return 2637;
      53: return 2793; 54: return 2959; 55: return 3135; 56: return 3322;
      57: return 3520; 58: return 3729; 59: return 3951;
      default: return 0;
    endcase
  endfunction

  // Half-period in clocks; silent indices map to 0 and are never used.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned idx);
    int unsigned f;
    f = note_hz(idx);
    return (f == 0) ? 0 : clk_hz / (2 * f);
  endfunction

  // A note index is sounding only inside 1..59.
  function automatic logic is_note(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'd59);
  endfunction

  // NOTE: the ROM is pure constants resolved at elaboration, so it has no
  // reset and no write port; only the per-channel state registers are reset.
  logic [CNT_W-1:0] hp_rom [64];

  for (genvar g = 0; g < 64; g++) begin : g_rom
    localparam int unsigned HP_G = half_period(CLK_HZ, g);
    assign hp_rom[g] = CNT_W'(HP_G);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [7:0]       cur_q,      cur_d;
    logic [7:0]       pend_q,     pend_d;
    logic             pend_f_q,   pend_f_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             tone_q,     tone_d;
    logic [31:0]      hold_cnt_q, hold_cnt_d;

    logic [7:0]       note_w;
    logic             vld_w;
    logic             cur_ok;
    logic             expire;
    logic [CNT_W-1:0] hp_w;

    assign note_w = note_in[8*i +: 8];
    assign vld_w  = note_vld[i];
    assign cur_ok = is_note(cur_q);
    assign hp_w   = hp_rom[cur_q[5:0]];
    assign expire = cur_ok && (cnt_q >= hp_w);

    // Next-state for one voice: period counter, edge-aligned retune, hold timeout.
    always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // branches below leaves one unassigned, which would infer a latch.
      cur_d      = cur_q;
      pend_d     = pend_q;
      pend_f_d   = pend_f_q;
      cnt_d      = cnt_q;
      tone_d     = tone_q;
      hold_cnt_d = hold_cnt_q;

      if (!cur_ok) begin
        // Silent: park the counter and load a new note straight into cur.
        tone_d   = 1'b0;
        cnt_d    = CNT_W'(1);
        pend_f_d = 1'b0;
        if (vld_w) cur_d = note_w;
      end else if (expire) begin
        // Waveform edge: the only place the sounding note may change.
        cnt_d    = CNT_W'(1);
        pend_f_d = 1'b0;
        if (vld_w) begin
          cur_d  = note_w;
          tone_d = is_note(note_w) ? ~tone_q : 1'b0;
        end else if (pend_f_q) begin
          cur_d  = pend_q;
          tone_d = is_note(pend_q) ? ~tone_q : 1'b0;
        end else begin
          tone_d = ~tone_q;
        end
      end else begin
        // Mid half-period: count, and park any update until the next edge.
        cnt_d = cnt_q + 1'b1;
        if (vld_w) begin
          pend_d   = note_w;
          pend_f_d = 1'b1;
        end
      end

      if (vld_w) begin
        hold_cnt_d = '0;
      end else if (HOLD_CLKS != 0 && cur_ok) begin
        if (hold_cnt_q == 32'(HOLD_CLKS - 1)) begin
          // Auto-release: a strobe in this same cycle takes the branch above.
          cur_d      = 8'd0;
          tone_d     = 1'b0;
          cnt_d      = CNT_W'(1);
          pend_f_d   = 1'b0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
    end

    // Voice state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cur_q      <= 8'd0;
        pend_q     <= 8'd0;
        pend_f_q   <= 1'b0;
        cnt_q      <= CNT_W'(1);
        tone_q     <= 1'b0;
        hold_cnt_q <= '0;
      end else begin
        // NOTE: non-blocking assignments let every register sample the
        // pre-edge state, so ordering inside this block does not matter.
        cur_q      <= cur_d;
        pend_q     <= pend_d;
        pend_f_q   <= pend_f_d;
        cnt_q      <= cnt_d;
        tone_q     <= tone_d;
        hold_cnt_q <= hold_cnt_d;
      end
    end

    assign tone[i]   = tone_q;
    assign active[i] = cur_ok;
  end

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [CH_W-1:0]   slot_q,     slot_d;
  logic              beep_q,     beep_d;

  // Mixer next-state: OR of all voices, or one voice per time slot.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    slot_d     = slot_q;
    beep_d     = |tone;
    if (MIX_MODE == 1) begin
      beep_d = tone[slot_q];
      if (slot_cnt_q == SLOT_W'(SLOT_CLKS - 1)) begin
        slot_cnt_d = '0;
        slot_d     = (slot_q == CH_W'(CHANNELS - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
    end
  end

  // Mixer registers; beep therefore lags the voice outputs by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      slot_q     <= '0;
      beep_q     <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      slot_q     <= slot_d;
      beep_q     <= beep_d;
    end
  end

  assign beep = beep_q;

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed bench for tone_synth. Three instances share clock and
// reset: a plain OR-mixed one, one with a 5000-clock hold timer, and one with
// the round-robin mixer at 100 clocks per slot. All run at CLK_HZ = 1 MHz, so
// HP(21)=1136, HP(33)=568, HP(59)=126, HP(1)=3623, HP(12)=1915, HP(24)=956,
// HP(45)=284.
module tb_tone_synth;

  localparam int A = 0;
  localparam int H = 1;
  localparam int M = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_note, h_note, m_note;
  logic [3:0]  a_vld, h_vld, m_vld;
  logic [3:0]  a_tone, h_tone, m_tone;
  logic [3:0]  a_act, h_act, m_act;
  logic        a_beep, h_beep, m_beep;
  logic        mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tone_synth #(.CLK_HZ(1_000_000), .CHANNELS(4), .CNT_W(20), .HOLD_CLKS(0),
               .MIX_MODE(0), .SLOT_CLKS(1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .note_in(a_note), .note_vld(a_vld),
    .tone(a_tone), .active(a_act), .beep(a_beep));

  tone_synth #(.CLK_HZ(1_000_000), .CHANNELS(4), .CNT_W(20), .HOLD_CLKS(5000),
               .MIX_MODE(0), .SLOT_CLKS(1000)) dut_h (
    .clk(clk), .rst_n(rst_n), .note_in(h_note), .note_vld(h_vld),
    .tone(h_tone), .active(h_act), .beep(h_beep));

  tone_synth #(.CLK_HZ(1_000_000), .CHANNELS(4), .CNT_W(20), .HOLD_CLKS(0),
               .MIX_MODE(1), .SLOT_CLKS(100)) dut_m (
    .clk(clk), .rst_n(rst_n), .note_in(m_note), .note_vld(m_vld),
    .tone(m_tone), .active(m_act), .beep(m_beep));

  typedef struct {
    int sel;
    int ch;
    int pre;
    int note;
    int exp1;
    int exp2;
  } vec_t;

  task automatic check(input bit ok, input string name, input longint act,
                       input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_tone(input int sel, input int ch);
    case (sel)
      A:       return a_tone[ch];
      H:       return h_tone[ch];
      default: return m_tone[ch];
    endcase
  endfunction

  function automatic logic get_act(input int sel, input int ch);
    case (sel)
      A:       return a_act[ch];
      H:       return h_act[ch];
      default: return m_act[ch];
    endcase
  endfunction

  task automatic load(input int sel, input int ch, input logic [7:0] note);
    case (sel)
      A:       begin a_note[8*ch +: 8] = note; a_vld[ch] = 1'b1; end
      H:       begin h_note[8*ch +: 8] = note; h_vld[ch] = 1'b1; end
      default: begin m_note[8*ch +: 8] = note; m_vld[ch] = 1'b1; end
    endcase
    tick();
    a_vld = '0;
    h_vld = '0;
    m_vld = '0;
  endtask

  // Clocks until the channel's tone changes; -1 if it does not within budget.
  task automatic measure(input int sel, input int ch, input int budget, output int n);
    logic t0;
    t0 = get_tone(sel, ch);
    n  = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (get_tone(sel, ch) !== t0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic tick_n(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Mixer monitor: beep after edge e must equal the pre-edge tone selected by
  // the slot in force, slot = ((e-1)/100) mod 4 counted from reset release.
  initial begin : mix_monitor
    int e;
    int win_a;
    int win_m;
    logic [3:0] pa;
    logic [3:0] pm;
    logic exp_m;
    e = 0; win_a = 0; win_m = 0; pa = '0; pm = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        e++;
        exp_m = pm[((e - 1) / 100) % 4];
        if (m_beep !== exp_m) win_m++;
        if (a_beep !== (|pa)) win_a++;
        if (e % 100 == 0) begin
          check(win_m == 0, $sformatf("mix_rr_window_%0d", e / 100), win_m, 0);
          check(win_a == 0, $sformatf("mix_or_window_%0d", e / 100), win_a, 0);
          win_m = 0;
          win_a = 0;
        end
      end
      pa = a_tone;
      pm = m_tone;
    end
  end

  initial begin : main
    vec_t vecs[7];
    int n;
    int errs;
    logic t_prev;

    vecs[0] = '{A, 0, 499, 33, 636, 568};
    vecs[1] = '{A, 0, 0,   59, 567, 126};
    vecs[2] = '{A, 0, 125, 1,  3623, 3623};
    vecs[3] = '{A, 2, 0,   12, 1915, 1915};
    vecs[4] = '{A, 3, 0,   59, 126,  126};
    vecs[5] = '{H, 1, 0,   45, 284,  284};
    vecs[6] = '{H, 2, 0,   24, 956,  956};

    rst_n  = 1'b0;
    a_note = '0; h_note = '0; m_note = '0;
    a_vld  = '0; h_vld  = '0; m_vld  = '0;

    #12;
    check(a_tone == 4'd0, "reset_tone", a_tone, 0);
    check(a_act == 4'd0, "reset_active", a_act, 0);
    check(a_beep == 1'b0, "reset_beep", a_beep, 0);
    check(m_beep == 1'b0, "reset_beep_rr", m_beep, 0);

    #10;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    // Round-robin instance: ch0 = 21 and ch2 = 33 captured at edge 1.
    m_note = {8'd0, 8'd33, 8'd0, 8'd21};
    m_vld  = 4'b0101;
    tick();
    m_vld  = '0;
    tick_n(8);
    check(a_act == 4'd0, "idle_after_release", a_act, 0);

    // Load 21 on ch0 at edge 10.
    load(A, 0, 8'd21);
    check(a_act[0] == 1'b1, "load_active", a_act[0], 1);
    check(a_tone[0] == 1'b0, "load_tone_low", a_tone[0], 0);
    measure(A, 0, 5000, n);
    check(n == 1136, "first_rise_21", n, 1136);
    check(a_beep == 1'b0, "beep_lag_pre", a_beep, 0);
    tick();
    check(a_beep == 1'b1, "beep_lag_post", a_beep, 1);
    measure(A, 0, 5000, n);
    check(n == 1135, "half_21_a", n, 1135);
    measure(A, 0, 5000, n);
    check(n == 1136, "half_21_b", n, 1136);

    // Retunes and silent-channel loads, each starting right after a toggle.
    for (int v = 0; v < 7; v++) begin
      tick_n(vecs[v].pre);
      load(vecs[v].sel, vecs[v].ch, 8'(vecs[v].note));
      check(get_act(vecs[v].sel, vecs[v].ch) == 1'b1,
            $sformatf("vec%0d_active", v), get_act(vecs[v].sel, vecs[v].ch), 1);
      measure(vecs[v].sel, vecs[v].ch, 5000, n);
      check(n == vecs[v].exp1, $sformatf("vec%0d_half1", v), n, vecs[v].exp1);
      measure(vecs[v].sel, vecs[v].ch, 5000, n);
      check(n == vecs[v].exp2, $sformatf("vec%0d_half2", v), n, vecs[v].exp2);
    end

    // Pending silent note (0) takes effect only at the expiry edge.
    load(A, 1, 8'd59);
    measure(A, 1, 5000, n);
    check(n == 126, "ch1_first_rise", n, 126);
    load(A, 1, 8'd0);
    tick_n(124);
    check(a_act[1] == 1'b1 && a_tone[1] == 1'b1, "pend0_still_on", a_act[1], 1);
    tick();
    check(a_act[1] == 1'b0, "pend0_active_drop", a_act[1], 0);
    check(a_tone[1] == 1'b0, "pend0_tone_low", a_tone[1], 0);

    // Same with an out-of-range index.
    load(A, 1, 8'd59);
    measure(A, 1, 5000, n);
    check(n == 126, "ch1_rise_again", n, 126);
    load(A, 1, 8'd60);
    tick_n(124);
    check(a_act[1] == 1'b1, "pend60_still_on", a_act[1], 1);
    tick();
    check(a_act[1] == 1'b0 && a_tone[1] == 1'b0, "pend60_silenced", a_act[1], 0);

    // Newest pending update wins: 0 then 33 before the edge.
    load(A, 1, 8'd59);
    measure(A, 1, 5000, n);
    check(n == 126, "ch1_rise_third", n, 126);
    load(A, 1, 8'd0);
    load(A, 1, 8'd33);
    tick_n(123);
    check(a_tone[1] == 1'b1, "override_pre_edge", a_tone[1], 1);
    tick();
    check(a_act[1] == 1'b1 && a_tone[1] == 1'b0, "override_edge", a_act[1], 1);
    measure(A, 1, 5000, n);
    check(n == 568, "override_half", n, 568);

    // Hold timer: silence exactly 5000 clocks after a single load.
    load(H, 0, 8'd21);
    tick_n(4999);
    check(h_act[0] == 1'b1, "hold_before_timeout", h_act[0], 1);
    tick();
    check(h_act[0] == 1'b0 && h_tone[0] == 1'b0, "hold_timeout", h_act[0], 0);
    tick_n(50);
    check(h_act[0] == 1'b0, "hold_stays_silent", h_act[0], 0);

    // Re-strobe one clock before timeout restarts the timer.
    load(H, 0, 8'd21);
    tick_n(4998);
    load(H, 0, 8'd21);
    check(h_act[0] == 1'b1, "restrobe_alive", h_act[0], 1);
    measure(H, 0, 5000, n);
    check(n == 681, "restrobe_tone_continues", n, 681);
    tick_n(4318);
    check(h_act[0] == 1'b1, "restrobe_before_timeout", h_act[0], 1);
    tick();
    check(h_act[0] == 1'b0, "restrobe_timeout", h_act[0], 0);

    // Strobe coincident with timeout: the new note plays.
    load(H, 0, 8'd33);
    tick_n(4999);
    load(H, 0, 8'd21);
    check(h_act[0] == 1'b1, "coincident_alive", h_act[0], 1);
    measure(H, 0, 5000, n);
    check(n == 112, "coincident_edge", n, 112);
    measure(H, 0, 5000, n);
    check(n == 1136, "coincident_new_note", n, 1136);

    // Asynchronous reset mid half-period with all four voices sounding.
    mon_en = 1'b0;
    tick();
    tick();
    check(a_act == 4'hF, "all_active_pre_reset", a_act, 15);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(a_tone == 4'd0, "async_reset_tone", a_tone, 0);
    check(a_act == 4'd0, "async_reset_active", a_act, 0);
    check(a_beep == 1'b0 && m_beep == 1'b0, "async_reset_beep", a_beep, 0);
    #2;
    rst_n = 1'b1;
    errs = 0;
    t_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (a_tone != 4'd0 || a_act != 4'd0 || a_beep != 1'b0) errs++;
      t_prev = t_prev | (|m_tone);
    end
    check(errs == 0, "silent_after_reset", errs, 0);
    check(t_prev == 1'b0, "silent_after_reset_rr", t_prev, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
# tone_synth

Parametrised multi-channel square-wave tone generator, successor to the single-channel piano buzzer driver. Each channel takes a semitone note index, converts it to a half-period through a fixed 59-entry equal-temperament table scaled by `CLK_HZ`, and emits a square wave. Channels switch notes glitch-free on waveform edges and can auto-release after a hold timeout. A mixer combines all channels into one `beep` output for the board buzzer.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz, used for half-period scaling.
- `CHANNELS`, 4, number of independent voices (1..8).
- `CNT_W`, 20, width of the per-channel period counter; must hold `HP(1)`.
- `HOLD_CLKS`, 0, auto-release timeout in clocks; 0 disables it.
- `MIX_MODE`, 0, 0 = OR of all channel tones; 1 = round-robin time-multiplex.
- `SLOT_CLKS`, 1000, clocks per channel slot in `MIX_MODE` 1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `note_in`  in  8*CHANNELS  note index per channel; slice i is bits [8i+7:8i].
- `note_vld`  in  CHANNELS  per-channel load strobe, one cycle per update.
- `tone`  out  CHANNELS  per-channel square wave.
- `active`  out  CHANNELS  high while the channel's current note is non-silent.
- `beep`  out  1  mixed buzzer drive.

## Operation
- Note table: index 1..59 covers C#3..B7 in semitones, with integer Hz values from the team table. Anchors: 1→138, 12→261, 21→440, 33→880, 59→3951.
- Half-period: `HP(n) = CLK_HZ / (2*F(n))`, integer division, computed at elaboration into a ROM.
- Index 0 or >59 = silent.
- Per channel, registers: `cur` (8b), `pend` (8b), `pend_f`, `cnt` (CNT_W), `tone`, `hold_cnt` (32b).
- Silent channel:
  - `tone`=0, `cnt`=1.
  - `note_vld` loads `cur` directly at that edge; `cnt`←1, `tone` stays 0.
- Sounding channel:
  - `cnt` increments each clock.
  - When `cnt` >= `HP(cur)`: `cnt`←1 and `tone` toggles.
- Update while sounding:
  - `note_vld` writes `pend` and sets `pend_f`; a later `note_vld` overwrites it (newest wins).
  - At the next expiry, `cur`←`pend` and `pend_f` clears.
  - If `pend` is valid, `tone` toggles as normal.
  - If `pend` is silent, `tone`←0.
- `note_vld` coincident with expiry: the incoming value is applied at that edge and `pend` is ignored.
- Hold timer (`HOLD_CLKS` > 0):
  - `hold_cnt`←0 on `note_vld`; it increments while `active`.
  - When `hold_cnt` = `HOLD_CLKS`-1: `cur`←0, `tone`←0, `cnt`←1, `pend_f`←0.
  - `note_vld` in the same cycle wins.
- `active[i]` = (`cur` is valid).
- Mixer, mode 0: `beep` = OR of `tone`, registered.
- Mixer, mode 1:
  - `slot_cnt` counts 0..`SLOT_CLKS`-1; `slot` advances 0..CHANNELS-1 and wraps.
  - `beep` = `tone[slot]`, registered.
  - Silent channels are not skipped; their slot yields 0.

## Timing
- Reset (async assert, sync release): `tone`=0, `active`=0, `beep`=0, `cur`=`pend`=0, `pend_f`=0, `cnt`=1, `hold_cnt`=0, `slot`=0, `slot_cnt`=0.
- Reset mid-tone clears everything immediately; there is no partial period on release.
- Load latency:
  - `note_vld` at edge k on a silent channel → `active` high after edge k.
  - First `tone` rise after edge k+`HP`.
- `tone` period = 2·`HP` clocks exactly, with no jitter across retunes.
- `beep` lags `tone` by one clock.
- Mode 1 slot boundaries occur every `SLOT_CLKS` clocks from reset release.
- Inputs are synchronous to `clk`; the block does no synchronisation.

## Test plan
1. `CLK_HZ`=1_000_000, ch0 `note_vld` with 21 at cycle 10 → `active[0]`=1 at cycle 11; `tone[0]` toggles every 1136 clocks (period 2272); `beep` follows one clock later.
2. ch0 sounding 21, 500 clocks into a half-period load 33 → that toggle still lands at 1136; subsequent half-periods are 568. Edge values: 59 → HP=126; 1 → HP=3623.
3. ch0 sounding, load 0, then separately load 60 → `tone` falls to 0 and `active` drops at the next expiry edge, not earlier; a second `note_vld` before expiry overrides the first.
4. `HOLD_CLKS`=5000:
   - Single load → silence exactly 5000 clocks later.
   - Re-strobe at 4999 → timer restarts and the tone continues.
   - Strobe coincident with timeout → the new note plays.
5. `MIX_MODE`=1, `SLOT_CLKS`=100, ch0=21 and ch2=33 active → `beep` tracks ch0 over clocks 0-99, is 0 over 100-199, tracks ch2 over 200-299, is 0 over 300-399, then wraps.
6. Assert `rst_n` low asynchronously mid-half-period with all four channels sounding → all outputs 0 without a clock edge; after release, no tone until a new `note_vld`.
